mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit address/data.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  1  CPU access request, sampled only in IDLE.
REQ-005 wr  input  1  1 = store, 0 = load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 sgn  input  1  1 = sign-extend loaded byte/half, 0 = zero-extend.
REQ-008 addr  input  32  CPU byte address.
REQ-009 wdata  input  32  store data; byte/half taken from low bits.
REQ-010 ready  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  load result, valid while ready=1.
REQ-012 misalign  output  1  error flag, high only together with ready.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 mem_a  output  32  word-aligned address to the word memory, {addr_q[31:2],2'b00}.
REQ-015 mem_we  output  1  memory write enable; write occurs on the rising edge.
REQ-016 mem_wd  output  32  memory write data.
REQ-017 mem_rd  input  32  memory read data, combinational from mem_a.

Function
REQ-018 Byte order SHALL be little-endian: byte offset k occupies bits [8k+7:8k].
REQ-019 FSM states SHALL be IDLE, READ, WRITE, DONE, ERR.
REQ-020 In IDLE with req=1, the block SHALL register addr, wr, size, sgn, wdata and move to ERR if misaligned, else to READ.
- Misaligned means: size=11; size=01 with addr[0]=1; or size=10 with addr[1:0]≠00.
REQ-021 READ SHALL latch mem_rd into a read buffer, then go to DONE for loads or WRITE for stores.
REQ-022 WRITE SHALL assert mem_we for exactly one cycle, then go to DONE.
- Word store: mem_wd = wdata_q.
- Byte/half store: mem_wd = read buffer with the addressed byte/half replaced by wdata_q[7:0]/[15:0].
REQ-023 DONE and ERR SHALL each last one cycle, assert ready=1, and return to IDLE; ERR also asserts misalign=1.
REQ-024 rdata in DONE for loads SHALL be the addressed byte/half/word, sign- or zero-extended per sgn_q; for stores and ERR, rdata SHALL be 0.
REQ-025 Latency, counting the req-sampled cycle as cycle 0, SHALL be:
- ready in cycle 2 for loads, cycle 3 for stores, cycle 1 for misaligned requests.
REQ-026 req SHALL be ignored in every state except IDLE; a req held high through DONE starts a new access only in the following IDLE cycle.
REQ-027 mem_we SHALL be 0 in every state except WRITE and SHALL never assert for misaligned requests.
REQ-028 mem_a SHALL be driven from the registered address in READ and WRITE; in other states its value is don't-care but SHALL be deterministic.

Reset
REQ-029 While rst_n=0 at a rising edge, the block SHALL enter IDLE, clear all registered fields to 0, and drive ready=0, misalign=0, rdata=0, busy=0.
REQ-030 mem_we SHALL be gated by rst_n, so no memory write occurs at an edge where rst_n=0, including reset asserted during WRITE.
REQ-031 Reset asserted mid-access SHALL abort it with no ready pulse.

Verification
REQ-032 Load word: memory word 0x40 = 0x8BADF00D; lw at addr 0x40 -> ready in cycle 2, rdata=0x8BADF00D, mem_we never high.
REQ-033 Load byte, same word, addr 0x43:
- sgn=1 -> rdata=0xFFFFFF8B.
- sgn=0 -> rdata=0x0000008B.
REQ-034 Load half, same word, addr 0x42:
- sgn=1 -> rdata=0xFFFF8BAD.
- sgn=0 -> rdata=0x00008BAD.
REQ-035 Store byte: sb at addr 0x41 with wdata=0x123456AA -> one mem_we pulse, mem_wd=0x8BADAA0D, ready in cycle 3; a subsequent lw at 0x40 returns 0x8BADAA0D.
REQ-036 Misaligned access:
- lw at addr 0x42 -> ready=1 and misalign=1 in cycle 1, mem_we stays 0, memory unchanged.
- size=11 at addr 0x40 -> same response.
REQ-037 Reset during a store: rst_n=0 during WRITE of a sw at 0x40 -> no write (word stays 0x8BADF00D), next state IDLE, no ready pulse; the next req is accepted normally.

Source files
------------

// File: rtl/mem_lsu_if.sv
// CPU-side access bus and word-memory port of the load/store unit.
// The master side is the environment (CPU plus word memory); the LSU is the slave.
interface mem_lsu_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        misalign;
  logic        busy;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req, wr, size, sgn, addr, wdata, mem_rd,
    input  ready, rdata, misalign, busy, mem_a, mem_we, mem_wd
  );

  modport slave (
    input  req, wr, size, sgn, addr, wdata, mem_rd,
    output ready, rdata, misalign, busy, mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: byte/half/word accesses to a 32-bit word memory, with
// read-modify-write for sub-word stores and a one-cycle error path for misalignment.
module mem_lsu (
  input  logic      clk,
  input  logic      rst_n,
  mem_lsu_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf;
  logic        wr_q;
  logic        sgn_q;
  logic [1:0]  size_q;

  logic        misaligned;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign misaligned = (bus.size == 2'b11) ||
                      (bus.size == 2'b01 && bus.addr[0]) ||
                      (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
    end else begin
      if (state == IDLE && bus.req) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        wr_q    <= bus.wr;
        sgn_q   <= bus.sgn;
        size_q  <= bus.size;
      end
      if (state == READ) rbuf <= bus.mem_rd;
    end
  end

  // Little-endian lane selection from the buffered word, shared by loads and stores.
  assign byte_sh   = {addr_q[1:0], 3'b000};
  assign half_sh   = {addr_q[1], 4'b0000};
  assign byte_mask = 32'h0000_00FF << byte_sh;
  assign half_mask = 32'h0000_FFFF << half_sh;
  assign ld_half   = addr_q[1] ? rbuf[31:16] : rbuf[15:0];

  always_comb begin
    ld_byte = rbuf[7:0];
    case (addr_q[1:0])
      2'b00:   ld_byte = rbuf[7:0];
      2'b01:   ld_byte = rbuf[15:8];
      2'b10:   ld_byte = rbuf[23:16];
      default: ld_byte = rbuf[31:24];
    endcase
  end

  always_comb begin
    load_val  = rbuf;
    merge_val = wdata_q;
    case (size_q)
      2'b00: begin
        load_val  = {{24{sgn_q & ld_byte[7]}}, ld_byte};
        merge_val = (rbuf & ~byte_mask) | ({4{wdata_q[7:0]}} & byte_mask);
      end
      2'b01: begin
        load_val  = {{16{sgn_q & ld_half[15]}}, ld_half};
        merge_val = (rbuf & ~half_mask) | ({2{wdata_q[15:0]}} & half_mask);
      end
      default: begin
        load_val  = rbuf;
        merge_val = wdata_q;
      end
    endcase
  end

  assign bus.mem_a  = {addr_q[31:2], 2'b00};
  assign bus.mem_wd = merge_val;

  // Completion outputs are also gated by rst_n so a reset never exposes a ready pulse.
  always_comb begin
    state_next   = state;
    bus.ready    = 1'b0;
    bus.misalign = 1'b0;
    bus.rdata    = '0;
    bus.busy     = 1'b1;
    bus.mem_we   = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.req) state_next = misaligned ? ERR : READ;
      end
      READ:  state_next = wr_q ? WRITE : DONE;
      WRITE: begin
        bus.mem_we = rst_n;
        state_next = DONE;
      end
      DONE: begin
        bus.ready  = rst_n;
        bus.rdata  = (wr_q || !rst_n) ? 32'h0 : load_val;
        state_next = IDLE;
      end
      ERR: begin
        bus.ready    = rst_n;
        bus.misalign = rst_n;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus pushes expected responses, a negedge
// monitor pops and compares them whenever the LSU signals ready.
module tb_mem_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        misalign;
    int          latency;
    int          writes;
    logic [31:0] wd;
    int          issue;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem [0:63];
  int          cyc;
  int          wr_total;
  int          wr_at_ready;
  logic [31:0] last_wd;
  int          checks;
  int          fails;
  exp_t        sb[$];

  mem_lsu_if bus();

  mem_lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rd = (bus.mem_a[31:8] == 24'h0 && bus.mem_a[1:0] == 2'b00) ?
                      mem[bus.mem_a[7:2]] : 32'hDEAD_BEEF;

  // Word memory model plus a running count of the writes it has accepted.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_we) begin
      mem[bus.mem_a[7:2]] = bus.mem_wd;
      wr_total = wr_total + 1;
      last_wd  = bus.mem_wd;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_ready: got ready=1, expected no response pending");
      end else begin
        e = sb.pop_front();
        checkOutput("rdata", bus.rdata, e.rdata);
        checkOutput("misalign", {31'h0, bus.misalign}, {31'h0, e.misalign});
        checkOutput("latency", 32'(cyc - e.issue), 32'(e.latency));
        checkOutput("write_count", 32'(wr_total - wr_at_ready), 32'(e.writes));
        if (e.writes > 0) checkOutput("mem_wd", last_wd, e.wd);
      end
      wr_at_ready = wr_total;
    end
  end

  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic exp_mis,
                               input int lat, input int nwr, input logic [31:0] exp_wd);
    exp_t e;
    @(negedge clk);
    bus.wr    = w;
    bus.size  = sz;
    bus.sgn   = sg;
    bus.addr  = a;
    bus.wdata = wd;
    bus.req   = 1'b1;
    e.rdata    = exp_rd;
    e.misalign = exp_mis;
    e.latency  = lat;
    e.writes   = nwr;
    e.wd       = exp_wd;
    e.issue    = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.req = 1'b0;
    #1;
    for (int k = 0; k < 8 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL response_timeout: got no ready for addr 0x%08h, expected ready within %0d cycles", a, lat);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int wr_before;
    checks      = 0;
    fails       = 0;
    cyc         = 0;
    wr_total    = 0;
    wr_at_ready = 0;
    last_wd     = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[16]   = 32'h8BAD_F00D;
    rst_n     = 1'b0;
    bus.req   = 1'b0;
    bus.wr    = 1'b0;
    bus.size  = 2'b00;
    bus.sgn   = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'h0, bus.ready}, 32'h0);
    checkOutput("rst_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("rst_misalign", {31'h0, bus.misalign}, 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    rst_n = 1'b1;

    // Loads from the word 0x8BADF00D at 0x40.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h8BAD_F00D, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 32'hFFFF_FF8B, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 32'h0000_008B, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'hFFFF_8BAD, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h0000_8BAD, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 32'h0000_000D, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'hFFFF_F00D, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'h0000_00F0, 1'b0, 2, 0, 32'h0);

    // Reset while a word store sits in WRITE: no write, no ready, clean restart.
    @(negedge clk);
    bus.wr    = 1'b1;
    bus.size  = 2'b10;
    bus.sgn   = 1'b0;
    bus.addr  = 32'h40;
    bus.wdata = 32'h1122_3344;
    bus.req   = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    checkOutput("we_in_write", {31'h0, bus.mem_we}, 32'h1);
    wr_before = wr_total;
    rst_n = 1'b0;
    #1;
    checkOutput("we_gated_by_reset", {31'h0, bus.mem_we}, 32'h0);
    @(negedge clk);
    checkOutput("abort_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("abort_ready", {31'h0, bus.ready}, 32'h0);
    checkOutput("abort_writes", 32'(wr_total - wr_before), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h8BAD_F00D, 1'b0, 2, 0, 32'h0);

    // Stores: sub-word read-modify-write and a full word.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_56AA, 32'h0, 1'b0, 3, 1, 32'h8BAD_AA0D);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h8BAD_AA0D, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h42, 32'hCAFE_1234, 32'h0, 1'b0, 3, 1, 32'h1234_AA0D);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234_AA0D, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'h0000_1234, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h47, 32'h0, 32'hFFFF_FFDE, 1'b0, 2, 0, 32'h0);

    // Misaligned and illegal-size requests, then confirm memory is untouched.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h41, 32'h0000_FFFF, 32'h0, 1'b1, 1, 0, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h46, 32'h5555_5555, 32'h0, 1'b1, 1, 0, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234_AA0D, 1'b0, 2, 0, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
